lcd_refresh_ctrl: RTL and testbench

Sequencer for the 16x2 HD44780-compatible character LCD. After power-up it runs the controller initialisation, then continuously rewrites both display lines from an internal 32-byte character buffer. Any design block, such as the BCD-to-ASCII formatter that turns the three display values into digits, writes characters into the buffer through a simple one-cycle write port and never touches LCD timing. The block sits between the display-formatting logic and the LCD pins at the board top level.

---
 rtl/lcd_refresh_ctrl_if.sv | 20 ++
 rtl/lcd_refresh_ctrl.sv | 90 +++++++++
 tb/tb_lcd_refresh_ctrl.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/lcd_refresh_ctrl_if.sv
// lcd_refresh_ctrl_if: character write port plus LCD pin bundle
// master: formatter/bench side (drives char_*, observes status and pins)
// slave : lcd_refresh_ctrl side
interface lcd_refresh_ctrl_if;
  logic       char_we;
  logic [4:0] char_addr;
  logic [7:0] char_data;
  logic       init_done;
  logic       frame_done;
  logic       LCD_ON;
  logic       LCD_BLON;
  logic       LCD_RW;
  logic       LCD_EN;
  logic       LCD_RS;
  logic [7:0] LCD_DATA;
  modport master(output char_we, char_addr, char_data,
                 input init_done, frame_done, LCD_ON, LCD_BLON, LCD_RW, LCD_EN, LCD_RS, LCD_DATA);
  modport slave(input char_we, char_addr, char_data,
                output init_done, frame_done, LCD_ON, LCD_BLON, LCD_RW, LCD_EN, LCD_RS, LCD_DATA);
endinterface

// File: rtl/lcd_refresh_ctrl.sv
// lcd_refresh_ctrl: HD44780 16x2 init + continuous refresh from a 32-byte buffer
// clock_50/reset: clock, async active-high reset
// bus (slave): char_we/char_addr/char_data buffer write; init_done, frame_done status;
//              LCD_ON/BLON/RW/EN/RS/DATA display pins
module lcd_refresh_ctrl #(
  parameter int POWERUP_CYCLES = 750000,
  parameter int EN_CYCLES      = 25,
  parameter int WAIT_CYCLES    = 2500,
  parameter int CLEAR_CYCLES   = 100000
) (
  input logic clock_50,
  input logic reset,
  lcd_refresh_ctrl_if.slave bus
);
  localparam int M1   = POWERUP_CYCLES > CLEAR_CYCLES ? POWERUP_CYCLES : CLEAR_CYCLES;
  localparam int M2   = EN_CYCLES > WAIT_CYCLES ? EN_CYCLES : WAIT_CYCLES;
  localparam int MAXC = M1 > M2 ? M1 : M2;
  localparam int CW   = $clog2(MAXC + 1);
  typedef enum logic [2:0] {PWRUP, INIT, L1_ADDR, L1_CHARS, L2_ADDR, L2_CHARS} st_t;
  typedef enum logic [1:0] {SETUP, PULSE, HOLD} ph_t;
  st_t r_st, w_st_n, w_tst;
  ph_t r_ph, w_ph_n;
  logic [CW-1:0] r_cnt, w_lim;
  logic [3:0] r_idx, w_tidx;
  logic [7:0] r_buf [32];
  logic [7:0] r_data, w_tbyte;
  logic r_rs, r_init, r_frame, w_end, w_adv;
  // w_tst/w_tidx/w_tbyte describe the transaction that starts on the next w_adv edge
  always_comb begin
    w_lim = r_st == PWRUP ? CW'(POWERUP_CYCLES - 1) :
            r_ph == SETUP ? '0 :
            r_ph == PULSE ? CW'(EN_CYCLES - 1) :
            r_data == 8'h01 ? CW'(CLEAR_CYCLES - 1) : CW'(WAIT_CYCLES - 1);
    w_end = r_cnt == w_lim;
    w_adv = w_end && (r_st == PWRUP || r_ph == HOLD);
    w_tst = r_st;
    w_tidx = r_idx + 4'd1;
    case (r_st)
      PWRUP:    begin w_tst = INIT; w_tidx = '0; end
      INIT:     if (r_idx == 4'd3) begin w_tst = L1_ADDR; w_tidx = '0; end
      L1_ADDR:  begin w_tst = L1_CHARS; w_tidx = '0; end
      L1_CHARS: if (r_idx == 4'd15) begin w_tst = L2_ADDR; w_tidx = '0; end
      L2_ADDR:  begin w_tst = L2_CHARS; w_tidx = '0; end
      default:  if (r_idx == 4'd15) begin w_tst = L1_ADDR; w_tidx = '0; end
    endcase
    w_tbyte = w_tst == INIT ? (w_tidx[1:0] == 2'd0 ? 8'h38 : w_tidx[1:0] == 2'd1 ? 8'h0C :
                               w_tidx[1:0] == 2'd2 ? 8'h01 : 8'h06) :
              w_tst == L1_ADDR ? 8'h80 :
              w_tst == L2_ADDR ? 8'hC0 : r_buf[{w_tst == L2_CHARS, w_tidx}];
    w_st_n = w_adv ? w_tst : r_st;
    w_ph_n = w_adv ? SETUP : !w_end ? r_ph : r_ph == SETUP ? PULSE : HOLD;
  end
  always_ff @(posedge clock_50 or posedge reset)
    if (reset) begin
      r_st <= PWRUP;
      r_ph <= SETUP;
    end else begin
      r_st <= w_st_n;
      r_ph <= w_ph_n;
    end
  // the buffer read in w_tbyte sees the pre-edge value, so a same-edge write lands next frame
  always_ff @(posedge clock_50 or posedge reset)
    if (reset) begin
      r_cnt <= '0;
      r_idx <= '0;
      r_data <= '0;
      r_rs <= 1'b0;
      r_init <= 1'b0;
      r_frame <= 1'b0;
      for (int i = 0; i < 32; i++) r_buf[i] <= 8'h20;
    end else begin
      r_cnt <= w_end ? '0 : r_cnt == CW'(MAXC) ? r_cnt : r_cnt + CW'(1);
      if (w_adv) begin
        r_idx <= w_tidx;
        r_data <= w_tbyte;
        r_rs <= w_tst == L1_CHARS || w_tst == L2_CHARS;
      end
      if (w_adv && w_tst == L1_ADDR) r_init <= 1'b1;
      r_frame <= w_adv && w_tst == L1_ADDR && r_st == L2_CHARS;
      if (bus.char_we) r_buf[bus.char_addr] <= bus.char_data;
    end
  assign bus.LCD_EN = r_ph == PULSE;
  assign bus.LCD_RS = r_rs;
  assign bus.LCD_DATA = r_data;
  assign bus.LCD_RW = 1'b0;
  assign bus.LCD_ON = ~reset;
  assign bus.LCD_BLON = ~reset;
  assign bus.init_done = r_init;
  assign bus.frame_done = r_frame;
endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// tb_lcd_refresh_ctrl: randomized bench against a transaction-schedule model of the LCD sequencer
module tb_lcd_refresh_ctrl;
  localparam int P = 10, E = 3, W = 5, C = 20;
  localparam int FRAME = 34 * (1 + E + W);
  logic clock_50 = 1'b0;
  logic reset = 1'b1;
  lcd_refresh_ctrl_if bus();
  lcd_refresh_ctrl #(.POWERUP_CYCLES(P), .EN_CYCLES(E), .WAIT_CYCLES(W), .CLEAR_CYCLES(C))
    dut (.clock_50(clock_50), .reset(reset), .bus(bus));
  always #5 clock_50 = ~clock_50;
  int errors = 0, checks = 0, cyc = 0, t_init = -1, t_frame = -1;
  logic [7:0] mbuf [32];
  logic [7:0] m_data;
  int m_pcnt, m_seq, m_t, m_hold;
  bit m_run, m_rs, m_init, m_fd;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic model_reset();
    m_run = 0; m_pcnt = 0; m_seq = 0; m_t = 0; m_hold = W;
    m_data = 8'h00; m_rs = 0; m_init = 0; m_fd = 0;
    for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
  endtask
  // transaction s: 0..3 init commands, then 34-byte frames forever
  task automatic start(input int s);
    int k;
    m_seq = s;
    m_t = 0;
    if (s < 4) begin
      m_rs = 0;
      m_data = s == 0 ? 8'h38 : s == 1 ? 8'h0C : s == 2 ? 8'h01 : 8'h06;
    end else begin
      k = (s - 4) % 34;
      m_rs = k != 0 && k != 17;
      m_data = k == 0 ? 8'h80 : k == 17 ? 8'hC0 : k < 17 ? mbuf[k-1] : mbuf[k-2];
      if (k == 0) begin
        if (s == 4) m_init = 1;
        else m_fd = 1;
      end
    end
    m_hold = m_data == 8'h01 ? C : W;
  endtask
  task automatic model_step(input logic we, input logic [4:0] a, input logic [7:0] d);
    m_fd = 0;
    if (!m_run) begin
      m_pcnt++;
      if (m_pcnt == P) begin
        m_run = 1;
        start(0);
      end
    end else begin
      m_t++;
      if (m_t == 1 + E + m_hold) start(m_seq + 1);
    end
    if (we) mbuf[a] = d;
  endtask
  task automatic compare_all();
    check("en", 32'(bus.LCD_EN), 32'(m_run && m_t >= 1 && m_t <= E));
    check("rs", 32'(bus.LCD_RS), 32'(m_rs));
    check("data", 32'(bus.LCD_DATA), 32'(m_data));
    check("init_done", 32'(bus.init_done), 32'(m_init));
    check("frame_done", 32'(bus.frame_done), 32'(m_fd));
    check("rw", 32'(bus.LCD_RW), 32'd0);
    check("on", 32'(bus.LCD_ON), 32'(!reset));
    check("blon", 32'(bus.LCD_BLON), 32'(!reset));
  endtask
  task automatic tick(input logic we, input logic [4:0] a, input logic [7:0] d);
    bus.char_we = we;
    bus.char_addr = a;
    bus.char_data = d;
    @(posedge clock_50);
    if (!reset) model_step(we, a, d);
    @(negedge clock_50);
    cyc++;
    compare_all();
    if (bus.init_done && t_init < 0) t_init = cyc;
    if (bus.frame_done && t_frame < 0) t_frame = cyc;
  endtask
  // frame slot that the next edge will open, or -1
  function automatic int next_k();
    return (m_run && m_seq >= 3 && m_t == E + m_hold) ? (m_seq - 3) % 34 : -1;
  endfunction
  function automatic int cur_k();
    return (m_run && m_seq >= 4) ? (m_seq - 4) % 34 : -1;
  endfunction
  initial begin
    bit found;
    logic [7:0] old;
    bus.char_we = 0;
    bus.char_addr = '0;
    bus.char_data = '0;
    model_reset();
    @(negedge clock_50);
    repeat (3) tick(0, 0, 0);
    reset = 0;
    tick(1, 5'd0, 8'h31);
    tick(1, 5'd1, 8'h32);
    tick(1, 5'd31, 8'h37);
    for (int i = 0; i < 1000 && t_frame < 0; i++) tick(0, 0, 0);
    check("frame_gap", t_frame - t_init, FRAME);
    found = 0;
    for (int i = 0; i < 1000 && !found; i++)
      if (next_k() == 6) begin
        old = mbuf[5];
        tick(1, 5'd5, 8'h41);
        check("wr5_old", 32'(bus.LCD_DATA), 32'(old));
        found = 1;
      end else tick(0, 0, 0);
    check("wr5_found", 32'(found), 1);
    tick(0, 0, 0);
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (next_k() == 6) found = 1;
      tick(0, 0, 0);
    end
    check("wr5_new", 32'(bus.LCD_DATA), 32'h41);
    repeat (FRAME + 10) tick(1, 5'($urandom_range(31)), 8'($urandom));
    repeat (2 * FRAME) tick(0, 0, 0);
    found = 0;
    for (int i = 0; i < 1000 && !found; i++)
      if (cur_k() == 10 && m_t == 2) found = 1;
      else tick(0, 0, 0);
    check("pulse_found", 32'(found), 1);
    check("pre_rst_en", 32'(bus.LCD_EN), 1);
    reset = 1;
    #1;
    check("rst_en", 32'(bus.LCD_EN), 0);
    check("rst_data", 32'(bus.LCD_DATA), 0);
    check("rst_on", 32'(bus.LCD_ON), 0);
    check("rst_init", 32'(bus.init_done), 0);
    model_reset();
    tick(0, 0, 0);
    tick(1, 5'd3, 8'h55);
    reset = 0;
    t_init = -1;
    t_frame = -1;
    for (int i = 0; i < 1000 && t_frame < 0; i++) tick(0, 0, 0);
    check("frame_gap2", t_frame - t_init, FRAME);
    repeat (20) tick(0, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
